// File: rtl/irq_ctrl_wb_if.sv
// Wishbone classic slave bus bundle for the interrupt controller.
// Signals: cyc/stb/we/adr/dat_i from master; dat_o/ack_o from slave.
interface irq_ctrl_wb_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [1:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/irq_ctrl_wb.sv
// Machine external interrupt controller with Wishbone register access.
// Ports: clk_i, reset_i (async, active high), src_i[NSRC] request lines,
//   irq_ack_i core acknowledge, meip_o to core, wb Wishbone slave bundle.
//   Registers: 0 ENABLE, 1 PENDING (W1C), 2 TRIGGER (1=edge), 3 CLAIM.
module irq_ctrl_wb #(
    parameter int NSRC = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [NSRC-1:0] src_i,
    input  logic            irq_ack_i,
    output logic            meip_o,
    irq_ctrl_wb_if.slave    wb
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NSRC-1:0] s1_q, s2_q, s3_q;
    logic [NSRC-1:0] en_q, en_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] trig_q, trig_d;
    logic [4:0]      id_q, id_d;
    logic            valid_q, valid_d;
    logic            meip_q, meip_d;
    logic            ack_q, ack_d;
    logic [31:0]     dat_q, dat_d;

    logic            access, wr, complete, claim, any_pe;
    logic [NSRC-1:0] pe, rise, w1c, claim_mask, wdat;
    logic [4:0]      win_id;
    logic            unused_dat;

    function automatic logic [31:0] zext(input logic [NSRC-1:0] v);
        zext = 32'(v);
    endfunction

    // A new access is one not already acked; effects land on the ack edge.
    assign access   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign wr       = access & wb.wb_we_i;
    assign complete = wr & (wb.wb_adr_i == 2'd3);
    assign wdat     = wb.wb_dat_i[NSRC-1:0];

    if (NSRC < 32) begin : g_pad
        assign unused_dat = ^wb.wb_dat_i[31:NSRC];
    end else begin : g_nopad
        assign unused_dat = 1'b0;
    end

    assign pe     = pend_q & en_q;
    assign any_pe = |pe;
    assign rise   = s2_q & ~s3_q;

    // Lowest index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        win_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pe[i]) win_id = 5'(i);
        end
    end

    // Claim/interrupt FSM
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        valid_d = valid_q;
        claim   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (any_pe) state_d = S_ASSERT;
            end
            S_ASSERT: begin
                if (irq_ack_i) begin
                    if (any_pe) begin
                        id_d    = win_id;
                        valid_d = 1'b1;
                        claim   = 1'b1;
                        state_d = S_SERVICE;
                    end else begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (!any_pe) begin
                    state_d = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (complete) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        meip_d = (state_d == S_ASSERT);
    end

    assign claim_mask = claim ? (NSRC'(1) << win_id) : '0;

    // Register file and bus response
    always_comb begin
        en_d   = en_q;
        trig_d = trig_q;
        w1c    = '0;
        dat_d  = '0;
        ack_d  = access;
        if (wr) begin
            unique case (wb.wb_adr_i)
                2'd0:    en_d   = wdat;
                2'd1:    w1c    = wdat;
                2'd2:    trig_d = wdat;
                default: ;
            endcase
        end
        if (access) begin
            unique case (wb.wb_adr_i)
                2'd0:    dat_d = zext(en_q);
                2'd1:    dat_d = zext(pend_q);
                2'd2:    dat_d = zext(trig_q);
                default: dat_d = {valid_q, 26'b0, id_q};
            endcase
        end
        // Edge bits: a rise beats any clear; level bits track the line.
        pend_d = (trig_q & ((pend_q & ~(w1c | claim_mask)) | rise))
               | (~trig_q & s2_q);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            en_q    <= '0;
            pend_q  <= '0;
            trig_q  <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            meip_q  <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            s1_q    <= src_i;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            en_q    <= en_d;
            pend_q  <= pend_d;
            trig_q  <= trig_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            meip_q  <= meip_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    assign meip_o      = meip_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;

endmodule

// File: tb/tb_irq_ctrl_wb.sv
// Directed self-checking bench for irq_ctrl_wb (NSRC = 16).
// Drives the Wishbone interface and request lines, checks readback/meip.
module tb_irq_ctrl_wb;

    logic        clk;
    logic        reset;
    logic [15:0] src;
    logic        irq_ack;
    logic        meip;
    logic [31:0] rd;
    int          checks;
    int          errors;

    irq_ctrl_wb_if bus ();

    irq_ctrl_wb #(.NSRC(16)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .src_i     (src),
        .irq_ack_i (irq_ack),
        .meip_o    (meip),
        .wb        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb_rd(input logic [1:0] a, output logic [31:0] d);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = a;
        tick();
        chk("rd_ack", 32'(bus.wb_ack_o), 32'd1);
        d = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        tick();
        chk("rd_ack_low", 32'(bus.wb_ack_o), 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        wb_rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = a;
        bus.wb_dat_i = d;
        tick();
        chk("wr_ack", 32'(bus.wb_ack_o), 32'd1);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        tick();
        chk("wr_ack_low", 32'(bus.wb_ack_o), 32'd0);
    endtask

    task automatic wait_meip(input string tag, input logic lvl);
        int n;
        n = 0;
        while (meip !== lvl && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(meip), 32'(lvl));
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        src          = '0;
        irq_ack      = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_meip", 32'(meip), 32'd0);
        chk("rst_ack", 32'(bus.wb_ack_o), 32'd0);
        chk("rst_dat", bus.wb_dat_o, 32'd0);
        reset = 1'b0;
        tick();
        rd_chk("rst_enable", 2'd0, 32'd0);
        rd_chk("rst_pending", 2'd1, 32'd0);
        rd_chk("rst_trigger", 2'd2, 32'd0);
        rd_chk("rst_claim", 2'd3, 32'd0);

        // Held cycle is acked exactly once
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_adr_i = 2'd0;
        tick();
        chk("hold_ack1", 32'(bus.wb_ack_o), 32'd1);
        tick();
        chk("hold_ack2", 32'(bus.wb_ack_o), 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        tick();

        // Bits above NSRC ignored
        wb_wr(2'd0, 32'hFFFF_FFFF);
        rd_chk("en_mask", 2'd0, 32'h0000_FFFF);
        wb_wr(2'd2, 32'hA5A5_1234);
        rd_chk("trig_mask", 2'd2, 32'h0000_1234);

        // Edge source 0: latency and claim
        wb_wr(2'd0, 32'h1);
        wb_wr(2'd2, 32'h1);
        src[0] = 1'b1;
        tick();
        tick();
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 2'd1;
        tick();
        chk("lat_ack", 32'(bus.wb_ack_o), 32'd1);
        chk("lat_pend_early", bus.wb_dat_o, 32'd0);
        chk("lat_meip_early", 32'(meip), 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        tick();
        chk("lat_meip", 32'(meip), 32'd1);
        rd_chk("e0_pending", 2'd1, 32'h1);
        pulse_ack();
        chk("e0_meip_drop", 32'(meip), 32'd0);
        rd_chk("e0_claim", 2'd3, 32'h8000_0000);
        rd_chk("e0_pend_clr", 2'd1, 32'h0);
        pulse_ack();
        rd_chk("svc_ack_ignored", 2'd3, 32'h8000_0000);
        chk("svc_meip", 32'(meip), 32'd0);
        wb_wr(2'd3, 32'h0);
        wb_rd(2'd3, rd);
        chk("e0_valid_clr", 32'(rd[31]), 32'd0);
        chk("e0_meip_idle", 32'(meip), 32'd0);
        src[0] = 1'b0;

        // Priority between edge sources 3 and 5
        wb_wr(2'd2, 32'h29);
        wb_wr(2'd0, 32'h28);
        src[3] = 1'b1;
        src[5] = 1'b1;
        wait_meip("p_meip", 1'b1);
        rd_chk("p_pending", 2'd1, 32'h28);
        pulse_ack();
        rd_chk("p_claim3", 2'd3, 32'h8000_0003);
        rd_chk("p_pend5", 2'd1, 32'h20);
        wb_wr(2'd3, 32'hDEAD_BEEF);
        chk("p_rerise", 32'(meip), 32'd1);
        pulse_ack();
        rd_chk("p_claim5", 2'd3, 32'h8000_0005);
        rd_chk("p_pend0", 2'd1, 32'h0);
        wb_wr(2'd3, 32'h0);
        chk("p_meip_idle", 32'(meip), 32'd0);
        src[3] = 1'b0;
        src[5] = 1'b0;

        // Level source 2
        wb_wr(2'd0, 32'h4);
        src[2] = 1'b1;
        wait_meip("l_meip", 1'b1);
        pulse_ack();
        rd_chk("l_claim", 2'd3, 32'h8000_0002);
        wb_wr(2'd1, 32'h4);
        rd_chk("l_w1c_noeff", 2'd1, 32'h4);
        wb_wr(2'd3, 32'h0);
        chk("l_reassert", 32'(meip), 32'd1);
        pulse_ack();
        rd_chk("l_claim2", 2'd3, 32'h8000_0002);
        src[2] = 1'b0;
        tick(); tick(); tick();
        rd_chk("l_pend_low", 2'd1, 32'h0);
        wb_wr(2'd3, 32'h0);
        tick(); tick();
        chk("l_meip_stay0", 32'(meip), 32'd0);

        // Withdrawn request, ack in IDLE ignored
        wb_wr(2'd0, 32'h1);
        src[0] = 1'b1;
        wait_meip("w_meip", 1'b1);
        wb_wr(2'd0, 32'h0);
        chk("w_meip_fall", 32'(meip), 32'd0);
        pulse_ack();
        tick();
        chk("w_ack_ignored", 32'(meip), 32'd0);
        wb_rd(2'd3, rd);
        chk("w_valid0", 32'(rd[31]), 32'd0);
        rd_chk("w_pend_kept", 2'd1, 32'h1);
        wb_wr(2'd1, 32'h1);
        rd_chk("w_w1c", 2'd1, 32'h0);

        // W1C colliding with a new rise: set wins
        src[0] = 1'b0;
        tick(); tick(); tick();
        src[0] = 1'b1;
        tick();
        tick();
        wb_wr(2'd1, 32'h1);
        rd_chk("c_set_wins", 2'd1, 32'h1);
        wb_wr(2'd1, 32'h1);
        rd_chk("c_clr_after", 2'd1, 32'h0);

        // Reset while in SERVICE
        wb_wr(2'd0, 32'h1);
        src[0] = 1'b0;
        tick(); tick(); tick();
        src[0] = 1'b1;
        wait_meip("r_meip", 1'b1);
        pulse_ack();
        rd_chk("r_claim", 2'd3, 32'h8000_0000);
        reset        = 1'b1;
        src          = '0;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 2'd0;
        tick();
        chk("r_in_meip", 32'(meip), 32'd0);
        chk("r_in_ack", 32'(bus.wb_ack_o), 32'd0);
        chk("r_in_dat", bus.wb_dat_o, 32'd0);
        reset = 1'b0;
        tick();
        chk("r_first_ack", 32'(bus.wb_ack_o), 32'd1);
        chk("r_first_dat", bus.wb_dat_o, 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        tick();
        chk("r_ack_low", 32'(bus.wb_ack_o), 32'd0);
        rd_chk("r_enable", 2'd0, 32'd0);
        rd_chk("r_pending", 2'd1, 32'd0);
        rd_chk("r_trigger", 2'd2, 32'd0);
        rd_chk("r_claim0", 2'd3, 32'd0);
        chk("r_meip", 32'(meip), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl_wb.md
IRQ_CTRL_WB -- requirements
Module: irq_ctrl_wb

Interface
REQ-001 The block SHALL have parameter NSRC, default 16, legal range 1..31, giving the number of interrupt sources.
REQ-002 clk_i  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset_i  input  1  asynchronous, active-high reset.
REQ-004 src_i  input  NSRC  asynchronous interrupt request lines, one per source.
REQ-005 irq_ack_i  input  1  single-cycle core acknowledge of the machine external interrupt.
REQ-006 meip_o  output  1  machine external interrupt pending, to the core; registered.
REQ-007 wb_cyc_i, wb_stb_i, wb_we_i  input  1 each  Wishbone classic slave cycle, strobe and write enable.
REQ-008 wb_adr_i  input  2  word address, selecting ENABLE=0, PENDING=1, TRIGGER=2, CLAIM=3.
REQ-009 wb_dat_i  input  32  Wishbone write data.
REQ-010 wb_dat_o  output  32  Wishbone read data.
REQ-011 wb_ack_o  output  1  Wishbone acknowledge.

Function
REQ-012 Each src_i bit SHALL pass through a 2-flop synchronizer before any use.
REQ-013 TRIGGER[i] SHALL select the trigger mode of source i: 1 = rising-edge, 0 = level.
REQ-014 Edge sources: PENDING[i] SHALL set when the synchronized value rises; a rise sampled at edge N SHALL be visible in PENDING after edge N+2.
REQ-015 Edge sources: PENDING[i] SHALL clear on a PENDING write with wb_dat_i[i]=1 (W1C), or when source i is claimed.
REQ-016 Edge sources: if a set and a clear occur in the same cycle, the set SHALL win.
REQ-017 Level sources: PENDING[i] SHALL mirror the synchronized level every cycle; W1C and claim SHALL have no effect on it.
REQ-018 Register bits at or above NSRC SHALL read 0, and writes to them SHALL be ignored.
REQ-019 Wishbone: wb_ack_o SHALL pulse high for exactly one cycle, one cycle after wb_cyc_i&wb_stb_i is first seen.
REQ-020 Wishbone: wb_ack_o SHALL be low in the cycle following an ack, so that one access is acked once.
REQ-021 Wishbone: the register write and wb_dat_o SHALL take effect in the same cycle that wb_ack_o is high.
REQ-022 ENABLE and TRIGGER SHALL be read/write.
REQ-023 CLAIM read SHALL return {valid[31], 26'b0, id[4:0]}.
REQ-024 Any CLAIM write SHALL be a "complete" and is data-independent.
REQ-025 Priority: the lowest index i with PENDING[i]&ENABLE[i] SHALL win.
REQ-026 The FSM SHALL have three states, IDLE, ASSERT and SERVICE; meip_o SHALL be 1 only in ASSERT.
REQ-027 IDLE -> ASSERT SHALL occur when |(PENDING&ENABLE); meip_o SHALL rise on the following edge.
REQ-028 ASSERT -> IDLE SHALL occur if PENDING&ENABLE becomes 0 before an ack (withdrawn request), with meip_o falling on that edge.
REQ-029 ASSERT with irq_ack_i=1 SHALL capture the winning id, set valid=1, clear an edge source's PENDING bit, drop meip_o and go to SERVICE, all on that edge.
REQ-030 ASSERT with irq_ack_i=1 and nothing pending in the same cycle SHALL set valid=0 and return to IDLE.
REQ-031 SERVICE: meip_o SHALL stay 0 (no nesting) and irq_ack_i SHALL be ignored.
REQ-032 SERVICE: a CLAIM write SHALL clear valid and go to IDLE; meip_o SHALL re-rise no earlier than 1 cycle later if sources are still pending.
REQ-033 irq_ack_i SHALL be ignored in IDLE.
REQ-034 Writes to ENABLE, PENDING and TRIGGER SHALL be accepted in every state.

Reset
REQ-035 While reset_i=1, ENABLE, PENDING, TRIGGER, claim id/valid, the synchronizer flops, meip_o, wb_ack_o and wb_dat_o SHALL be 0 and the FSM SHALL be in IDLE.
REQ-036 Reset asserted mid-transaction SHALL abort any in-progress claim and any Wishbone access with no ack issued; the block SHALL resume from the REQ-035 state on release.

Verification
REQ-037 The bench SHALL cover: ENABLE=0x0001, TRIGGER=0x0001, src_i[0] rises at edge N -> PENDING=0x0001 after N+2, meip_o=1 after N+3; irq_ack_i pulse -> meip_o=0, CLAIM reads 0x80000000, PENDING=0.
REQ-038 The bench SHALL cover: edge sources 3 and 5 pending and enabled -> first claim id=3; after CLAIM write, meip_o re-rises and second claim id=5.
REQ-039 The bench SHALL cover: level source 2 held high, ENABLE=0x0004 -> after claim and complete, meip_o re-asserts; src_i[2] low, then complete -> meip_o stays 0.
REQ-040 The bench SHALL cover: in ASSERT, write ENABLE=0 before ack -> meip_o falls next edge, FSM in IDLE, a later irq_ack_i is ignored.
REQ-041 The bench SHALL cover: W1C to PENDING in the same cycle as a new rising edge on that source -> bit remains 1.
REQ-042 The bench SHALL cover: reset_i pulsed while in SERVICE -> all registers read 0, meip_o=0, and the first post-reset Wishbone read acks after one cycle.
